// File: rtl/ras_ckpt_if.sv
// ----------------------------------------------------------------------------
// ras_ckpt_if : fetch-side bundle for the checkpointable return address stack.
//
// Signals
//   push_valid / push_target      call seen, return address to push
//   pop_valid                     return seen, pop the top entry
//   restore_valid / restore_ptr /
//   restore_count                 reload a previously captured checkpoint
//   top_valid / top_target        predicted return target (stack non-empty)
//   ckpt_ptr / ckpt_count         checkpoint of the current stack state
//   underflow                     one-cycle pulse after a pop on an empty stack
//
// Modports
//   master : fetch / backend side (drives requests, observes the stack)
//   slave  : the stack itself
// ----------------------------------------------------------------------------
interface ras_ckpt_if #(
   parameter int LOG_DEPTH    = 3,
   parameter int TARGET_WIDTH = 12
);

   logic                    push_valid;
   logic [TARGET_WIDTH-1:0] push_target;
   logic                    pop_valid;
   logic                    restore_valid;
   logic [LOG_DEPTH-1:0]    restore_ptr;
   logic [LOG_DEPTH:0]      restore_count;
   logic                    top_valid;
   logic [TARGET_WIDTH-1:0] top_target;
   logic [LOG_DEPTH-1:0]    ckpt_ptr;
   logic [LOG_DEPTH:0]      ckpt_count;
   logic                    underflow;

   modport master (
      output push_valid, push_target, pop_valid,
             restore_valid, restore_ptr, restore_count,
      input  top_valid, top_target, ckpt_ptr, ckpt_count, underflow
   );

   modport slave (
      input  push_valid, push_target, pop_valid,
             restore_valid, restore_ptr, restore_count,
      output top_valid, top_target, ckpt_ptr, ckpt_count, underflow
   );

endinterface

// File: rtl/ras_ckpt.sv
// ----------------------------------------------------------------------------
// ras_ckpt : circular, checkpointable return address stack for fetch.
//
// Fetch pushes the return address on a call and pops on a return; the top
// entry is the predicted return target. Every cycle the stack exposes its
// {ptr, count} as a checkpoint; the backend restores a captured checkpoint on
// a mispredict or flush. Entries are never copied, so a restore only reloads
// the pointer and occupancy.
//
// Ports
//   CLK            clock, rising edge
//   RST            synchronous active-high reset
//   ras (slave)    request/response bundle, see ras_ckpt_if
//   overflow_cnt   (optional) saturating count of pushes onto a full stack
//   underflow_cnt  (optional) saturating count of pops from an empty stack
//
// Build option
//   RAS_CKPT_PERF_CNT_EN  when defined, adds the two performance counters.
//
// Edge priority: RST > restore_valid > push/pop.
// ----------------------------------------------------------------------------
module ras_ckpt #(
   parameter int DEPTH        = 8,
   parameter int LOG_DEPTH    = $clog2(DEPTH),
   parameter int TARGET_WIDTH = 12
) (
   input  logic        CLK,
   input  logic        RST,
   ras_ckpt_if.slave   ras
`ifdef RAS_CKPT_PERF_CNT_EN
   ,
   output logic [15:0] overflow_cnt,
   output logic [15:0] underflow_cnt
`endif
);

   localparam logic [LOG_DEPTH:0]   CNT_FULL_C = (LOG_DEPTH+1)'(DEPTH);
   localparam logic [LOG_DEPTH:0]   CNT_ZERO_C = (LOG_DEPTH+1)'(1'b0);
   localparam logic [LOG_DEPTH:0]   CNT_ONE_C  = (LOG_DEPTH+1)'(1'b1);
   localparam logic [LOG_DEPTH-1:0] PTR_ZERO_C = LOG_DEPTH'(1'b0);
   localparam logic [LOG_DEPTH-1:0] PTR_ONE_C  = LOG_DEPTH'(1'b1);

   logic [TARGET_WIDTH-1:0] entries_r [DEPTH];
   logic [LOG_DEPTH-1:0]    ptr_r;
   logic [LOG_DEPTH:0]      count_r;
   logic                    underflow_r;

   logic [LOG_DEPTH-1:0]    ptr_nxt_s;
   logic [LOG_DEPTH:0]      count_nxt_s;
   logic                    underflow_nxt_s;
   logic                    wr_en_s;
   logic [LOG_DEPTH-1:0]    wr_idx_s;
   logic [LOG_DEPTH-1:0]    top_idx_s;
   logic                    empty_s;
   logic                    full_s;
   logic                    ovf_evt_s;
   logic                    unf_evt_s;

   // ptr points at the next free slot, so the top lives one below it (mod DEPTH)
   assign top_idx_s = ptr_r - PTR_ONE_C;
   assign empty_s   = (count_r == CNT_ZERO_C);
   assign full_s    = (count_r == CNT_FULL_C);

   // Next-state decode: restore wins over push/pop; underflow is a one-cycle pulse
   always_comb begin
      ptr_nxt_s       = ptr_r;
      count_nxt_s     = count_r;
      underflow_nxt_s = 1'b0;
      wr_en_s         = 1'b0;
      wr_idx_s        = ptr_r;
      ovf_evt_s       = 1'b0;
      unf_evt_s       = 1'b0;

      if (ras.restore_valid) begin
         // An out-of-range occupancy is clamped rather than trusted
         ptr_nxt_s = ras.restore_ptr;
         if (ras.restore_count > CNT_FULL_C) begin
            count_nxt_s = CNT_FULL_C;
         end else begin
            count_nxt_s = ras.restore_count;
         end
      end else if (ras.push_valid && ras.pop_valid && !empty_s) begin
         // Return-then-call: replace the top in place, depth unchanged
         wr_en_s  = 1'b1;
         wr_idx_s = top_idx_s;
      end else if (ras.push_valid) begin
         // A push onto a full stack silently overwrites the oldest entry
         wr_en_s   = 1'b1;
         wr_idx_s  = ptr_r;
         ptr_nxt_s = ptr_r + PTR_ONE_C;
         if (full_s) begin
            count_nxt_s = CNT_FULL_C;
            ovf_evt_s   = 1'b1;
         end else begin
            count_nxt_s = count_r + CNT_ONE_C;
         end
      end else if (ras.pop_valid) begin
         if (empty_s) begin
            underflow_nxt_s = 1'b1;
            unf_evt_s       = 1'b1;
         end else begin
            ptr_nxt_s   = ptr_r - PTR_ONE_C;
            count_nxt_s = count_r - CNT_ONE_C;
         end
      end else begin
         ptr_nxt_s   = ptr_r;
         count_nxt_s = count_r;
      end
   end

   // Pointer, occupancy and underflow pulse registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_r       <= PTR_ZERO_C;
         count_r     <= CNT_ZERO_C;
         underflow_r <= 1'b0;
      end else begin
         ptr_r       <= ptr_nxt_s;
         count_r     <= count_nxt_s;
         underflow_r <= underflow_nxt_s;
      end
   end

   // Entry storage; cleared on reset so top_target reads zero afterwards
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_r[i] <= {TARGET_WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         entries_r[wr_idx_s] <= ras.push_target;
      end
   end

`ifdef RAS_CKPT_PERF_CNT_EN
   logic [15:0] overflow_cnt_r;
   logic [15:0] underflow_cnt_r;

   // Saturating event counters; restore cycles never raise an event
   always_ff @(posedge CLK) begin
      if (RST) begin
         overflow_cnt_r  <= 16'h0000;
         underflow_cnt_r <= 16'h0000;
      end else begin
         if (ovf_evt_s && (overflow_cnt_r != 16'hFFFF)) begin
            overflow_cnt_r <= overflow_cnt_r + 16'h0001;
         end
         if (unf_evt_s && (underflow_cnt_r != 16'hFFFF)) begin
            underflow_cnt_r <= underflow_cnt_r + 16'h0001;
         end
      end
   end

   assign overflow_cnt  = overflow_cnt_r;
   assign underflow_cnt = underflow_cnt_r;
`else
   // Event strobes only feed the optional counters
   logic unused_evt_s;
   assign unused_evt_s = ovf_evt_s ^ unf_evt_s;
`endif

   // Outputs depend on registered state only
   assign ras.top_valid  = !empty_s;
   assign ras.top_target = entries_r[top_idx_s];
   assign ras.ckpt_ptr   = ptr_r;
   assign ras.ckpt_count = count_r;
   assign ras.underflow  = underflow_r;

endmodule

// File: tb/tb_ras_ckpt.sv
// ----------------------------------------------------------------------------
// tb_ras_ckpt : self-checking bench for ras_ckpt (DEPTH=8, TARGET_WIDTH=12).
// Directed scenarios plus a randomized run compared against an array model.
// ----------------------------------------------------------------------------
module tb_ras_ckpt;

   localparam int D  = 8;
   localparam int LD = 3;
   localparam int TW = 12;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   // Reference model: plain array plus integer pointer/occupancy
   logic [TW-1:0] m_ent [D];
   int            m_ptr;
   int            m_cnt;
   logic          m_und;
   int            m_ovf;
   int            m_unf;

   ras_ckpt_if #(.LOG_DEPTH(LD), .TARGET_WIDTH(TW)) bus ();

`ifdef RAS_CKPT_PERF_CNT_EN
   logic [15:0] ovf_cnt;
   logic [15:0] unf_cnt;
`endif

   ras_ckpt #(.DEPTH(D), .TARGET_WIDTH(TW)) dut (
      .CLK           (clk),
      .RST           (rst),
      .ras           (bus)
`ifdef RAS_CKPT_PERF_CNT_EN
      ,
      .overflow_cnt  (ovf_cnt),
      .underflow_cnt (unf_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs, update the model at the edge, settle 1 time unit
   task automatic step(input logic p, input logic [TW-1:0] t, input logic po,
                       input logic r, input logic [LD-1:0] rp, input logic [LD:0] rc,
                       input logic rs);
      rst               = rs;
      bus.push_valid    = p;
      bus.push_target   = t;
      bus.pop_valid     = po;
      bus.restore_valid = r;
      bus.restore_ptr   = rp;
      bus.restore_count = rc;
      @(posedge clk);
      if (rs) begin
         m_ptr = 0; m_cnt = 0; m_und = 1'b0; m_ovf = 0; m_unf = 0;
         for (int i = 0; i < D; i++) m_ent[i] = '0;
      end else if (r) begin
         m_ptr = int'(rp);
         m_cnt = (int'(rc) > D) ? D : int'(rc);
         m_und = 1'b0;
      end else if (p && po && m_cnt > 0) begin
         m_ent[(m_ptr + D - 1) % D] = t;
         m_und = 1'b0;
      end else if (p) begin
         if (m_cnt == D) m_ovf++;
         m_ent[m_ptr] = t;
         m_ptr = (m_ptr + 1) % D;
         m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
         m_und = 1'b0;
      end else if (po) begin
         if (m_cnt > 0) begin
            m_ptr = (m_ptr + D - 1) % D;
            m_cnt--;
            m_und = 1'b0;
         end else begin
            m_und = 1'b1;
            m_unf++;
         end
      end else begin
         m_und = 1'b0;
      end
      #1;
      rst               = 1'b0;
      bus.push_valid    = 1'b0;
      bus.pop_valid     = 1'b0;
      bus.restore_valid = 1'b0;
   endtask

   task automatic push(input logic [TW-1:0] t);
      step(1'b1, t, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
      step(1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (bus.top_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_top_valid: got %b want 0", bus.top_valid); end
      tests_run++; if (bus.top_target !== 12'h000) begin tests_failed++; $display("FAIL reset_top_target: got %h want 000", bus.top_target); end
      tests_run++; if (bus.ckpt_ptr !== 3'd0) begin tests_failed++; $display("FAIL reset_ptr: got %0d want 0", bus.ckpt_ptr); end
      tests_run++; if (bus.ckpt_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", bus.ckpt_count); end
      tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_underflow: got %b want 0", bus.underflow); end
   endtask

   task automatic test_basic();
      push(12'h111); push(12'h222); push(12'h333);
      tests_run++; if (bus.top_target !== 12'h333) begin tests_failed++; $display("FAIL basic_top3: got %h want 333", bus.top_target); end
      tests_run++; if (bus.ckpt_count !== 4'd3) begin tests_failed++; $display("FAIL basic_count3: got %0d want 3", bus.ckpt_count); end
      tests_run++; if (bus.ckpt_ptr !== 3'd3) begin tests_failed++; $display("FAIL basic_ptr3: got %0d want 3", bus.ckpt_ptr); end
      pop();
      tests_run++; if (bus.top_target !== 12'h222) begin tests_failed++; $display("FAIL basic_pop1: got %h want 222", bus.top_target); end
      pop();
      tests_run++; if (bus.top_target !== 12'h111) begin tests_failed++; $display("FAIL basic_pop2: got %h want 111", bus.top_target); end
      pop();
      tests_run++; if (bus.top_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_empty_valid: got %b want 0", bus.top_valid); end
      tests_run++; if (bus.ckpt_count !== 4'd0) begin tests_failed++; $display("FAIL basic_empty_count: got %0d want 0", bus.ckpt_count); end
   endtask

   task automatic test_overflow();
      logic [TW-1:0] exp_t;
      do_reset();
      for (int i = 1; i <= 9; i++) push(TW'(i));
      tests_run++; if (bus.ckpt_count !== 4'd8) begin tests_failed++; $display("FAIL ovf_count: got %0d want 8", bus.ckpt_count); end
      tests_run++; if (bus.ckpt_ptr !== 3'd1) begin tests_failed++; $display("FAIL ovf_ptr: got %0d want 1", bus.ckpt_ptr); end
      tests_run++; if (bus.top_target !== 12'h009) begin tests_failed++; $display("FAIL ovf_top: got %h want 009", bus.top_target); end
      for (int i = 0; i < 8; i++) begin
         exp_t = TW'(9 - i);
         tests_run++; if (bus.top_target !== exp_t) begin tests_failed++; $display("FAIL ovf_pop_seq%0d: got %h want %h", i, bus.top_target, exp_t); end
         pop();
      end
      tests_run++; if (bus.ckpt_count !== 4'd0) begin tests_failed++; $display("FAIL ovf_drained: got %0d want 0", bus.ckpt_count); end
      tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_no_unf: got %b want 0", bus.underflow); end
      pop();
      tests_run++; if (bus.underflow !== 1'b1) begin tests_failed++; $display("FAIL unf_pulse: got %b want 1", bus.underflow); end
      tests_run++; if (bus.ckpt_ptr !== 3'd1) begin tests_failed++; $display("FAIL unf_ptr: got %0d want 1", bus.ckpt_ptr); end
      tests_run++; if (bus.ckpt_count !== 4'd0) begin tests_failed++; $display("FAIL unf_count: got %0d want 0", bus.ckpt_count); end
      step(1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL unf_one_cycle: got %b want 0", bus.underflow); end
   endtask

   task automatic test_push_pop_same();
      do_reset();
      push(12'h055); push(12'h0AA);
      step(1'b1, 12'h0BB, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
      tests_run++; if (bus.top_target !== 12'h0BB) begin tests_failed++; $display("FAIL pp_top: got %h want 0bb", bus.top_target); end
      tests_run++; if (bus.ckpt_count !== 4'd2) begin tests_failed++; $display("FAIL pp_count: got %0d want 2", bus.ckpt_count); end
      tests_run++; if (bus.ckpt_ptr !== 3'd2) begin tests_failed++; $display("FAIL pp_ptr: got %0d want 2", bus.ckpt_ptr); end
      pop();
      tests_run++; if (bus.top_target !== 12'h055) begin tests_failed++; $display("FAIL pp_below: got %h want 055", bus.top_target); end
      pop();
      step(1'b1, 12'h0BB, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
      tests_run++; if (bus.ckpt_count !== 4'd1) begin tests_failed++; $display("FAIL pp_empty_count: got %0d want 1", bus.ckpt_count); end
      tests_run++; if (bus.top_target !== 12'h0BB) begin tests_failed++; $display("FAIL pp_empty_top: got %h want 0bb", bus.top_target); end
      tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL pp_empty_unf: got %b want 0", bus.underflow); end
      tests_run++; if (bus.ckpt_ptr !== 3'd1) begin tests_failed++; $display("FAIL pp_empty_ptr: got %0d want 1", bus.ckpt_ptr); end
   endtask

   task automatic test_restore();
      do_reset();
      push(12'h0C1); push(12'h0C2);
      push(12'h444); push(12'h555); pop();
      step(1'b1, 12'h777, 1'b0, 1'b1, 3'd2, 4'd2, 1'b0);
      tests_run++; if (bus.ckpt_ptr !== 3'd2) begin tests_failed++; $display("FAIL rst_ptr: got %0d want 2", bus.ckpt_ptr); end
      tests_run++; if (bus.ckpt_count !== 4'd2) begin tests_failed++; $display("FAIL rst_count: got %0d want 2", bus.ckpt_count); end
      tests_run++; if (bus.top_target !== 12'h0C2) begin tests_failed++; $display("FAIL rst_top: got %h want 0c2", bus.top_target); end
      step(1'b0, 12'h000, 1'b0, 1'b1, 3'd5, 4'd15, 1'b0);
      tests_run++; if (bus.ckpt_count !== 4'd8) begin tests_failed++; $display("FAIL rst_clamp: got %0d want 8", bus.ckpt_count); end
      tests_run++; if (bus.ckpt_ptr !== 3'd5) begin tests_failed++; $display("FAIL rst_clamp_ptr: got %0d want 5", bus.ckpt_ptr); end
      step(1'b0, 12'h000, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0);
      tests_run++; if (bus.underflow !== 1'b0) begin tests_failed++; $display("FAIL rst_pop_unf: got %b want 0", bus.underflow); end
      tests_run++; if (bus.top_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_empty: got %b want 0", bus.top_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) push(12'h100 + TW'(i));
      step(1'b1, 12'hABC, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
      tests_run++; if (bus.ckpt_count !== 4'd0) begin tests_failed++; $display("FAIL mid_count: got %0d want 0", bus.ckpt_count); end
      tests_run++; if (bus.ckpt_ptr !== 3'd0) begin tests_failed++; $display("FAIL mid_ptr: got %0d want 0", bus.ckpt_ptr); end
      tests_run++; if (bus.top_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b want 0", bus.top_valid); end
      tests_run++; if (bus.top_target !== 12'h000) begin tests_failed++; $display("FAIL mid_target: got %h want 000", bus.top_target); end
   endtask

   task automatic test_random();
      logic p, po, r, rs;
      logic [TW-1:0] t;
      logic [LD-1:0] rp;
      logic [LD:0] rc;
      for (int n = 0; n < 600; n++) begin
         p  = ($urandom_range(0, 99) < 50);
         po = ($urandom_range(0, 99) < 45);
         r  = ($urandom_range(0, 99) < 6);
         rs = ($urandom_range(0, 199) == 0);
         t  = TW'($urandom);
         rp = LD'($urandom);
         rc = (LD+1)'($urandom_range(0, 10));
         step(p, t, po, r, rp, rc, rs);
         tests_run++; if (bus.ckpt_ptr !== LD'(m_ptr)) begin tests_failed++; $display("FAIL rnd_ptr@%0d: got %0d want %0d", n, bus.ckpt_ptr, m_ptr); end
         tests_run++; if (bus.ckpt_count !== (LD+1)'(m_cnt)) begin tests_failed++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, bus.ckpt_count, m_cnt); end
         tests_run++; if (bus.top_valid !== (m_cnt != 0)) begin tests_failed++; $display("FAIL rnd_valid@%0d: got %b want %b", n, bus.top_valid, m_cnt != 0); end
         tests_run++; if (bus.underflow !== m_und) begin tests_failed++; $display("FAIL rnd_unf@%0d: got %b want %b", n, bus.underflow, m_und); end
         if (m_cnt != 0) begin
            tests_run++; if (bus.top_target !== m_ent[(m_ptr + D - 1) % D]) begin tests_failed++; $display("FAIL rnd_top@%0d: got %h want %h", n, bus.top_target, m_ent[(m_ptr + D - 1) % D]); end
         end
      end
   endtask

`ifdef RAS_CKPT_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      tests_run++; if (ovf_cnt !== 16'd0) begin tests_failed++; $display("FAIL perf_reset_ovf: got %0d want 0", ovf_cnt); end
      for (int i = 0; i < 10; i++) push(12'h200 + TW'(i));
      for (int i = 0; i < 12; i++) pop();
      tests_run++; if (ovf_cnt !== 16'd2) begin tests_failed++; $display("FAIL perf_ovf: got %0d want 2", ovf_cnt); end
      tests_run++; if (unf_cnt !== 16'd4) begin tests_failed++; $display("FAIL perf_unf: got %0d want 4", unf_cnt); end
      step(1'b0, 12'h000, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0);
      tests_run++; if (unf_cnt !== 16'd4) begin tests_failed++; $display("FAIL perf_restore_unf: got %0d want 4", unf_cnt); end
      tests_run++; if (unf_cnt !== 16'(m_unf)) begin tests_failed++; $display("FAIL perf_model_unf: got %0d want %0d", unf_cnt, m_unf); end
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst               = 1'b1;
      bus.push_valid    = 1'b0;
      bus.push_target   = '0;
      bus.pop_valid     = 1'b0;
      bus.restore_valid = 1'b0;
      bus.restore_ptr   = '0;
      bus.restore_count = '0;
      m_ptr = 0; m_cnt = 0; m_und = 1'b0; m_ovf = 0; m_unf = 0;
      for (int i = 0; i < D; i++) m_ent[i] = '0;
      test_reset();
      test_basic();
      test_overflow();
      test_push_pop_same();
      test_restore();
      test_reset_mid();
      test_random();
`ifdef RAS_CKPT_PERF_CNT_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
- Parametrised, checkpointable return address stack (RAS) for the fetch-stage branch predictor.
- Generalises the fixed RAS_DEPTH / RAS_TARGET_WIDTH constants into a circular stack of configurable depth and width.
- Each operation returns a {ptr, count} checkpoint. The backend can restore that checkpoint on a mispredict or flush, so the stack needs no copy.
- Sits beside the BTB. Fetch pushes on calls, pops on returns, and uses the top entry as the predicted return target.

Parameters:
- DEPTH, 8, number of entries; must be a power of 2 and ≥2.
- LOG_DEPTH, $clog2(DEPTH), pointer width.
- TARGET_WIDTH, 12, stored target bits, matching RAS_TARGET_WIDTH.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous active-high reset.
- push_valid  input  1  call seen; push push_target.
- push_target  input  TARGET_WIDTH  return address to push.
- pop_valid  input  1  return seen; pop top.
- restore_valid  input  1  restore checkpoint.
- restore_ptr  input  LOG_DEPTH  checkpointed pointer.
- restore_count  input  LOG_DEPTH+1  checkpointed occupancy.
- top_valid  output  1  stack non-empty (count != 0).
- top_target  output  TARGET_WIDTH  entry[ptr-1].
- ckpt_ptr  output  LOG_DEPTH  current pointer (next free slot).
- ckpt_count  output  LOG_DEPTH+1  current occupancy, 0..DEPTH.
- underflow  output  1  registered pulse: pop on empty last cycle.

Behaviour:
- Interface:
  - One clock; reset is synchronous and active-high.
  - CLK rising edge only; RST sampled on the edge.
- State:
  - entries[DEPTH] of TARGET_WIDTH bits.
  - ptr: LOG_DEPTH bits, wraps modulo DEPTH.
  - count: LOG_DEPTH+1 bits, saturates at DEPTH.
- Reset:
  - ptr=0, count=0, all entries=0, underflow=0.
  - Outputs after reset: top_valid=0, top_target=0, ckpt_ptr=0, ckpt_count=0.
  - Reset mid-operation overrides every input on that edge.
- Outputs:
  - top_valid, top_target, ckpt_ptr and ckpt_count are combinational from registered state. There is no input-to-output combinational path.
  - Updates take effect on the next edge (1-cycle latency).
- Priority on each edge: RST > restore_valid > push/pop.
- Restore:
  - ptr<=restore_ptr; count<=restore_count; entries unchanged.
  - push_valid and pop_valid are ignored that cycle; underflow<=0.
  - restore_count > DEPTH is illegal; the stack clamps it to DEPTH.
- Push only:
  - entries[ptr]<=push_target; ptr<=ptr+1 (wraps).
  - count<=min(count+1, DEPTH).
  - Push at count==DEPTH overwrites the oldest entry (circular overflow). No flag is raised.
- Pop only:
  - If count!=0: ptr<=ptr-1 (wraps); count<=count-1.
  - If count==0: ptr and count unchanged; underflow<=1 for one cycle.
- Push and pop in the same cycle (return-then-call, e.g. a tail call):
  - If count!=0: entries[ptr-1]<=push_target; ptr and count unchanged.
  - If count==0: behaves as a push only; no underflow.
- Idle cycle: state held; underflow<=0.
- Wrap-around:
  - All ptr arithmetic is modulo DEPTH.
  - top_target reads entries[(ptr-1) mod DEPTH], valid only when top_valid=1.

Optional Feature:
- Macro: RAS_CKPT_PERF_CNT_EN.
- Defined:
  - Adds output ports overflow_cnt [15:0] and underflow_cnt [15:0].
  - overflow_cnt counts pushes at count==DEPTH. underflow_cnt counts pops at count==0.
  - Both saturate at 16'hFFFF, reset to 0 on RST, and do not count on restore cycles.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then push 0x111, 0x222, 0x333 on consecutive cycles → top_target=0x333, ckpt_count=3, ckpt_ptr=3. Then 3 pops → top_target 0x222, 0x111, then top_valid=0, count=0.
- DEPTH=8: push 0x001..0x009 (9 pushes) → count=8, ptr=1, top_target=0x009. Then 8 pops return 0x009..0x002; the 9th pop on empty → underflow=1 for one cycle; ptr stays 1.
- With count=2 and top 0x0AA, assert push and pop together with target 0x0BB → top_target=0x0BB, count=2, ptr unchanged. Same on empty stack → count=1, top=0x0BB, underflow=0.
- Record ckpt_ptr=2/ckpt_count=2; push 0x444, 0x555, pop; then restore_valid with {2,2} together with push_valid → ptr=2, count=2, top_target = the original entries[1]; the push is ignored.
- Assert RST during a push at count=5 → next cycle count=0, ptr=0, top_valid=0, top_target=0.
- With RAS_CKPT_PERF_CNT_EN: 10 pushes at DEPTH=8 then 12 pops → overflow_cnt=2, underflow_cnt=4. A pop on empty during a restore cycle → no increment.
